// File: rtl/instr_encoder.sv
// Packs decoded fields + immediate into RISC-V I/S/B/J words and streams them to instruction memory.
// Define ENC_RANGE_CHECK_EN to reject out-of-range immediates (err/err_count); otherwise they are truncated.
module instr_encoder #(
    parameter int unsigned           ADDR_W    = 8,
    parameter logic [ADDR_W-1:0]     BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        imm_src,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   words_written,
    output logic              full,
    output logic              err,
    output logic [7:0]        err_count
);

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } immType_t;

    localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] ptr;
    logic [31:0]       encoded;
    logic              inRange;
    logic              accept;
    logic [ADDR_W:0]   nextWritten;

    assign in_ready    = !full && !start;
    assign accept      = in_valid && in_ready;
    assign nextWritten = words_written + 1'b1;

    always_comb begin
        encoded = '0;
        case (immType_t'(imm_src))
            IMM_I: encoded = {imm[11:0], rs1, funct3, rd, opcode};
            IMM_S: encoded = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            IMM_B: encoded = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            IMM_J: encoded = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: encoded = '0;
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    // Immediate fits when every bit above the encodable sign bit matches it.
    always_comb begin
        inRange = 1'b0;
        case (immType_t'(imm_src))
            IMM_I, IMM_S: inRange = (&imm[31:11]) || !(|imm[31:11]);
            IMM_B:        inRange = ((&imm[31:12]) || !(|imm[31:12])) && !imm[0];
            IMM_J:        inRange = ((&imm[31:20]) || !(|imm[31:20])) && !imm[0];
            default:      inRange = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err       <= 1'b0;
            err_count <= '0;
        end else if (start) begin
            err       <= 1'b0;
            err_count <= '0;
        end else if (accept && !inRange) begin
            err <= 1'b1;
            if (err_count != '1) begin
                err_count <= err_count + 1'b1;
            end
        end
    end
`else
    logic unusedImmBits;

    assign inRange       = 1'b1;
    assign err           = 1'b0;
    assign err_count     = '0;
    assign unusedImmBits = ^{imm[31:21], imm[0]};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr           <= BASE_ADDR;
            imem_we       <= 1'b0;
            imem_addr     <= '0;
            imem_wdata    <= '0;
            words_written <= '0;
            full          <= 1'b0;
        end else if (start) begin
            ptr           <= BASE_ADDR;
            imem_we       <= 1'b0;
            words_written <= '0;
            full          <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            // full registers alongside the filling strobe so no extra word slips in.
            if (accept && inRange) begin
                imem_we       <= 1'b1;
                imem_addr     <= ptr;
                imem_wdata    <= encoded;
                ptr           <= ptr + 1'b1;
                words_written <= nextWritten;
                full          <= (nextWritten == FULL_COUNT);
            end
        end
    end

endmodule
